// File: rtl/div_datapath.sv
// Datapath of the restoring shift-subtract unsigned divider: remainder/quotient
// shift register, divisor register, trial-subtract ALU and result capture.
module div_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  input  logic             W_ctrl,
  input  logic [5:0]       SUBU_ctrl,
  input  logic             SRL_ctrl,
  input  logic             SLL_ctrl,
  input  logic             Ready,
  output logic             MSB,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Valid,
  output logic             DivZero
);

  localparam logic [5:0] SUBU_OP = 6'b100011;

  logic [2*WIDTH:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             dz_q, dz_d;
  logic             ready_dly_q, ready_dly_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             valid_q, valid_d;
  logic             divzero_q, divzero_d;

  logic [WIDTH:0]   upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH+1:0] diff;
  logic             subu_active;
  logic             capture;

  // Upper part is WIDTH+1 bits so a large divisor never loses its top bit on shift.
  always_comb begin
    upper       = rem_q[2*WIDTH:WIDTH];
    lower       = rem_q[WIDTH-1:0];
    diff        = {1'b0, upper} - {2'b0, div_q};
    MSB         = diff[WIDTH+1];
    subu_active = (SUBU_ctrl == SUBU_OP);
  end

  always_comb begin
    rem_d = rem_q;
    div_d = div_q;
    dz_d  = dz_q;
    if (W_ctrl) begin
      rem_d = {{(WIDTH+1){1'b0}}, Dividend};
      div_d = Divisor;
      dz_d  = (Divisor == '0);
    end else if (subu_active && SLL_ctrl) begin
      if (!MSB) rem_d = {diff[WIDTH-1:0], lower, 1'b1};
      else      rem_d = {rem_q[2*WIDTH-1:0], 1'b0};
    end else if (subu_active) begin
      if (!MSB) rem_d = {diff[WIDTH:0], lower};
    end else if (SLL_ctrl && SRL_ctrl) begin
      rem_d = rem_q;
    end else if (SLL_ctrl) begin
      rem_d = {rem_q[2*WIDTH-1:0], 1'b0};
    end else if (SRL_ctrl) begin
      rem_d = {1'b0, upper[WIDTH:1], lower};
    end
  end

  // Results are captured only on the rising edge of Ready, so a held Ready pulses Valid once.
  always_comb begin
    ready_dly_d = Ready;
    capture     = Ready && !ready_dly_q;
    valid_d     = capture;
    quot_d      = quot_q;
    remd_d      = remd_q;
    divzero_d   = divzero_q;
    if (capture) begin
      quot_d    = lower;
      remd_d    = rem_q[2*WIDTH-1:WIDTH];
      divzero_d = dz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      rem_q       <= '0;
      div_q       <= '0;
      dz_q        <= 1'b0;
      ready_dly_q <= 1'b0;
      quot_q      <= '0;
      remd_q      <= '0;
      valid_q     <= 1'b0;
      divzero_q   <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      div_q       <= div_d;
      dz_q        <= dz_d;
      ready_dly_q <= ready_dly_d;
      quot_q      <= quot_d;
      remd_q      <= remd_d;
      valid_q     <= valid_d;
      divzero_q   <= divzero_d;
    end
  end

  assign Quotient  = quot_q;
  assign Remainder = remd_q;
  assign Valid     = valid_q;
  assign DivZero   = divzero_q;

endmodule
